// File: rtl/tpg_video_source.sv
// Video timing generator and test-pattern source feeding the TMDS encoders.
// Produces hsync/vsync/blank and 10-bit RGB, all registered and mutually aligned.
module tpg_video_source #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic        pixclk,
  input  logic        RESET_N,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [9:0]  red,
  output logic [9:0]  green,
  output logic [9:0]  blue,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;
  logic             start_q;
  logic [1:0]       pat_q;
  logic [23:0]      rgb_q;

  logic             h_last_c;
  logic             frame_end_c;
  logic             active_c;
  logic             hs_low_c;
  logic             vs_low_c;
  logic [7:0]       grey_c;
  logic             chk_c;
  logic [23:0]      pix_c;

  // Region decode for the current counter position
  always_comb begin
    h_last_c    = (h_cnt == H_LAST);
    frame_end_c = h_last_c && (v_cnt == V_LAST);
    active_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_low_c    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_low_c    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // Pattern colour for the current pixel; zero outside active video
  always_comb begin
    pix_c  = '0;
    grey_c = h_cnt[7:0] + frame_cnt;
    chk_c  = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
    if (active_c) begin
      unique case (pat_q)
        2'd0:    pix_c = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        2'd1:    pix_c = {grey_c, grey_c, grey_c};
        2'd2:    pix_c = chk_c ? 24'hFF_FF_FF : 24'h00_00_00;
        default: pix_c = rgb_q;
      endcase
    end
  end

  // Raster counters, bar counter, frame-boundary pattern latch and frame counter
  always_ff @(posedge pixclk or negedge RESET_N) begin
    if (!RESET_N) begin
      start_q   <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      pat_q     <= '0;
      rgb_q     <= '0;
      frame_cnt <= '0;
    end else if (!start_q) begin
      start_q <= 1'b1;
    end else begin
      if (h_last_c) begin
        h_cnt   <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        bar_px  <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + CNT_W'(1);
        end
      end
      if (frame_end_c) begin
        pat_q     <= pattern_sel;
        rgb_q     <= solid_rgb;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Output register stage; holds reset levels until the first pixel is evaluated
  always_ff @(posedge pixclk or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (start_q) begin
      hsync       <= ~hs_low_c;
      vsync       <= ~vs_low_c;
      blank       <= active_c;
      red         <= {2'b00, pix_c[23:16]};
      green       <= {2'b00, pix_c[15:8]};
      blue        <= {2'b00, pix_c[7:0]};
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_tpg_video_source.sv
// Bench for tpg_video_source using a reduced raster so several frames fit in a short run.
module tb_tpg_video_source;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 12, VFP = 2, VSY = 2, VBP = 2;
  localparam int CHK = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int BW = HA / 8;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  localparam out_t RST_VAL = out_t'({1'b1, 1'b1, 40'd0});

  logic        pixclk = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic        hsync, vsync, blank, frame_start;
  logic [9:0]  red, green, blue;
  logic [7:0]  frame_cnt;

  tpg_video_source #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CHK_LOG2(CHK)
  ) dut (
    .pixclk(pixclk), .RESET_N(RESET_N), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .blank(blank), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 pixclk = ~pixclk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int          m_h = 0, m_v = 0;
  bit          m_run = 1'b0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_rgb = 24'd0;
  logic [7:0]  m_fc = 8'd0;
  int          ev_h = -1, ev_v = -1;
  out_t        exp_q [$];

  // Timing monitor state
  int   cyc = 0;
  logic prev_bl = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  int   last_rise = -1, hs_fall = -1, last_fs = -1, vs_low = 0;
  bit   rise_in_line = 1'b0;
  logic [7:0] exp_fc = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic out_t model_px(input int h, input int v);
    out_t        e;
    logic [23:0] c;
    logic [7:0]  g;
    bit          act;
    act  = (h < HA) && (v < VA);
    e.hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    e.vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    e.bl = act;
    c    = 24'd0;
    if (act) begin
      case (m_pat)
        2'd0: c = bars[h / BW];
        2'd1: begin g = 8'((h % 256) + int'(m_fc)); c = {g, g, g}; end
        2'd2: c = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: c = m_rgb;
      endcase
    end
    e.r  = {2'b00, c[23:16]};
    e.g  = {2'b00, c[15:8]};
    e.b  = {2'b00, c[7:0]};
    e.fs = (h == 0) && (v == 0);
    e.fc = m_fc;
    return e;
  endfunction

  function automatic out_t dut_out();
    return {hsync, vsync, blank, red, green, blue, frame_start, frame_cnt};
  endfunction

  task automatic mon_clear();
    prev_bl = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    last_rise = -1; hs_fall = -1; last_fs = -1; vs_low = 0;
    rise_in_line = 1'b0; exp_fc = 8'd0;
  endtask

  // Sync/blank durations, line/frame periods and frame counter sequence
  task automatic monitor();
    if (frame_start) begin
      if (last_fs >= 0) chk("frame_period", 64'(cyc - last_fs), 64'(HT * VT));
      chk("frame_cnt_at_fs", 64'(frame_cnt), 64'(exp_fc));
      exp_fc++;
      last_fs   = cyc;
      last_rise = -1;
    end
    if (blank && !prev_bl) begin
      if (last_rise >= 0) chk("line_period", 64'(cyc - last_rise), 64'(HT));
      last_rise    = cyc;
      rise_in_line = 1'b1;
    end
    if (!blank && prev_bl && last_rise >= 0) chk("blank_len", 64'(cyc - last_rise), 64'(HA));
    if (!hsync && prev_hs) begin
      if (rise_in_line) chk("hsync_offset", 64'(cyc - last_rise), 64'(HA + HFP));
      rise_in_line = 1'b0;
      hs_fall      = cyc;
    end
    if (hsync && !prev_hs && hs_fall >= 0) chk("hsync_len", 64'(cyc - hs_fall), 64'(HSY));
    if (!vsync) vs_low++;
    if (vsync && !prev_vs) begin
      chk("vsync_len", 64'(vs_low), 64'(VSY * HT));
      vs_low = 0;
    end
    prev_bl = blank; prev_hs = hsync; prev_vs = vsync;
  endtask

  // One clock: predict, push, clock, pop and compare
  task automatic tick();
    out_t e;
    out_t got;
    if (!RESET_N) begin
      e = RST_VAL;
      m_h = 0; m_v = 0; m_run = 1'b0; m_pat = 2'd0; m_rgb = 24'd0; m_fc = 8'd0;
      ev_h = -1; ev_v = -1;
      mon_clear();
    end else if (!m_run) begin
      e = RST_VAL;
      m_run = 1'b1;
      ev_h = -1; ev_v = -1;
    end else begin
      e = model_px(m_h, m_v);
      ev_h = m_h; ev_v = m_v;
      if (m_h == HT - 1 && m_v == VT - 1) begin
        m_pat = pattern_sel; m_rgb = solid_rgb; m_fc = m_fc + 8'd1;
      end
      e.fc = m_fc;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    exp_q.push_back(e);
    @(posedge pixclk);
    #1;
    cyc++;
    got = dut_out();
    e = exp_q.pop_front();
    chk("scoreboard", 64'(got), 64'(e));
    if (RESET_N) monitor();
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(ev_h == h && ev_v == v) && n < HT * VT + 10);
    chk("run_to_reached", 64'(n < HT * VT + 10 || (ev_h == h && ev_v == v)), 64'(1));
  endtask

  function automatic logic [29:0] rgb30();
    return {red, green, blue};
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_hsync", 64'(hsync), 64'(1));
    chk("rst_vsync", 64'(vsync), 64'(1));
    chk("rst_blank", 64'(blank), 64'(0));
    chk("rst_rgb", 64'(rgb30()), 64'(0));
    RESET_N = 1'b1;

    // First edge after release still shows reset levels; second edge outputs (0,0)
    tick();
    chk("first_edge_fs", 64'(frame_start), 64'(0));
    tick();
    chk("pix00_fs", 64'(frame_start), 64'(1));
    chk("bar_white", 64'(rgb30()), 64'({10'h0FF, 10'h0FF, 10'h0FF}));

    // Colour bars on line 0
    run_to(BW, 0);
    chk("bar_yellow", 64'(rgb30()), 64'({10'h0FF, 10'h0FF, 10'h000}));
    run_to(6 * BW - 1, 0);
    chk("bar_red_edge", 64'(rgb30()), 64'({10'h0FF, 10'h000, 10'h000}));
    run_to(6 * BW, 0);
    chk("bar_blue", 64'(rgb30()), 64'({10'h000, 10'h000, 10'h0FF}));
    run_to(HA - 1, 0);
    chk("bar_black", 64'(rgb30()), 64'(0));
    chk("bar_last_blank", 64'(blank), 64'(1));
    run_to(HA, 0);
    chk("hblank_rgb", 64'(rgb30()), 64'(0));
    chk("hblank_blank", 64'(blank), 64'(0));

    // Mid-frame switch to solid colour takes effect next frame only
    run_to(0, 5);
    pattern_sel = 2'd3;
    solid_rgb   = 24'h12_34_56;
    run_to(2 * BW, VA - 1);
    chk("bars_continue", 64'(rgb30()), 64'({10'h000, 10'h0FF, 10'h0FF}));
    run_to(0, 0);
    chk("solid_red", 64'(red), 64'(10'h012));
    chk("solid_green", 64'(green), 64'(10'h034));
    chk("solid_blue", 64'(blue), 64'(10'h056));
    chk("solid_fc", 64'(frame_cnt), 64'(1));

    // Checkerboard next frame
    run_to(HA - 1, 3);
    chk("solid_late", 64'(rgb30()), 64'({10'h012, 10'h034, 10'h056}));
    pattern_sel = 2'd2;
    run_to(3, 0);
    chk("chk_3_0", 64'(rgb30()), 64'(0));
    run_to(4, 0);
    chk("chk_4_0", 64'(rgb30()), 64'({10'h0FF, 10'h0FF, 10'h0FF}));
    run_to(0, 4);
    chk("chk_0_4", 64'(rgb30()), 64'({10'h0FF, 10'h0FF, 10'h0FF}));
    run_to(4, 4);
    chk("chk_4_4", 64'(rgb30()), 64'(0));

    // Grey ramp in the frame with frame_cnt == 3
    pattern_sel = 2'd1;
    run_to(10, 0);
    chk("ramp_fc", 64'(frame_cnt), 64'(3));
    chk("ramp_10_0", 64'(rgb30()), 64'({10'h00D, 10'h00D, 10'h00D}));

    // Asynchronous reset mid-frame
    run_to(30, 5);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst", 64'(dut_out()), 64'(RST_VAL));
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    chk("rerelease_fs", 64'(frame_start), 64'(0));
    tick();
    chk("restart_fs", 64'(frame_start), 64'(1));
    chk("restart_fc", 64'(frame_cnt), 64'(0));
    chk("restart_bars", 64'(rgb30()), 64'({10'h0FF, 10'h0FF, 10'h0FF}));

    // One more full frame of scoreboard and timing checks
    run_to(0, 0);
    chk("next_fc", 64'(frame_cnt), 64'(1));
    run_to(12, 0);
    chk("next_ramp", 64'(rgb30()), 64'({10'h00D, 10'h00D, 10'h00D}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
